// File: rtl/ervp_user_gpio_pkg.sv
// ----------------------------------------------------------------------------
// ervp_user_gpio_pkg
// Shared definitions for the user GPIO bank: bit positions of the per-slot
// status/control word and the edge-detect MODE encoding. The same positions
// are mirrored in the software headers, so they must not move.
//   [0]   OUT   pad output value
//   [1]   OE    pad output enable
//   [3:2] MODE  00 off, 01 rise, 10 fall, 11 both
//   [4]   PEND  pending edge (write 1 clears)
//   [8]   IN    synchronized (optionally debounced) pad level, read-only
// ----------------------------------------------------------------------------
package ervp_user_gpio_pkg;

   localparam int GPIO_BIT_OUT  = 0;
   localparam int GPIO_BIT_OE   = 1;
   localparam int GPIO_LSB_MODE = 2;
   localparam int GPIO_BIT_PEND = 4;
   localparam int GPIO_BIT_IN   = 8;

   typedef enum logic [1:0] {
      GPIO_MODE_OFF  = 2'b00,
      GPIO_MODE_RISE = 2'b01,
      GPIO_MODE_FALL = 2'b10,
      GPIO_MODE_BOTH = 2'b11
   } gpio_mode_e;

   // True when the observed edge is one the configured MODE wants reported.
   function automatic logic edge_hit(input gpio_mode_e mode,
                                     input logic       rise,
                                     input logic       fall);
      logic hit;
      hit = 1'b0;
      case (mode)
         GPIO_MODE_RISE: hit = rise;
         GPIO_MODE_FALL: hit = fall;
         GPIO_MODE_BOTH: hit = rise | fall;
         default:        hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/ervp_user_gpio_channel.sv
// ----------------------------------------------------------------------------
// ervp_user_gpio_channel
// One GPIO slot: OUT/OE/MODE/PEND registers, 2-flop input synchronizer,
// optional debounce filter, edge detector and pending-flag logic.
// Optional feature macro: USER_GPIO_DEBOUNCE_EN (debounce filter between the
// synchronizer and the edge detector).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en           write strobe for this slot
//   wdata           32-bit write word for this slot
//   rdata           32-bit status word, combinational from registered state
//   gpio_i          raw pad input (asynchronous)
//   gpio_o, gpio_oe pad output value / enable
//   irq_term        PEND & (MODE != off), unregistered; the bank registers it
// ----------------------------------------------------------------------------
module ervp_user_gpio_channel
   import ervp_user_gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        gpio_i,
   output logic        gpio_o,
   output logic        gpio_oe,
   output logic        irq_term
);

   logic       out_q;
   logic       oe_q;
   gpio_mode_e mode_q;
   logic       pend_q;
   logic       sync_p0;
   logic       sync_p1;
   logic       filt_p2;
   logic       prev_p3;
   logic       rise;
   logic       fall;
   logic       set_evt;
   logic       clr_evt;
   logic       unused_wdata;

   // Upper bits and the read-only IN position are ignored on write.
   assign unused_wdata = ^wdata[31:5];

   // Control registers written by the decoder strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= 1'b0;
         oe_q   <= 1'b0;
         mode_q <= GPIO_MODE_OFF;
      end else if (wr_en) begin
         out_q  <= wdata[GPIO_BIT_OUT];
         oe_q   <= wdata[GPIO_BIT_OE];
         mode_q <= gpio_mode_e'(wdata[GPIO_LSB_MODE +: 2]);
      end
   end

   // Stage 0/1: two-flop synchronizer for the asynchronous pad input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= gpio_i;
         sync_p1 <= sync_p0;
      end
   end

   // Stage 2: filtered level.
`ifdef USER_GPIO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_p2;

   // The level is accepted once sync has disagreed with it for
   // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_p2  <= '0;
         filt_p2 <= 1'b0;
      end else if (sync_p1 == filt_p2) begin
         cnt_p2 <= '0;
      end else if (cnt_p2 == CNT_LAST) begin
         cnt_p2  <= '0;
         filt_p2 <= sync_p1;
      end else begin
         cnt_p2 <= cnt_p2 + CNT_W'(1);
      end
   end
`else
   localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
   assign filt_p2 = sync_p1;
`endif

   // Stage 3: delayed copy for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_p3 <= 1'b0;
      end else begin
         prev_p3 <= filt_p2;
      end
   end

   always_comb begin
      rise    = filt_p2 & ~prev_p3;
      fall    = ~filt_p2 & prev_p3;
      set_evt = edge_hit(mode_q, rise, fall);
      clr_evt = wr_en & wdata[GPIO_BIT_PEND];
   end

   // A set event in the same cycle as a W1C clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= set_evt | (pend_q & ~clr_evt);
      end
   end

   always_comb begin
      rdata                          = '0;
      rdata[GPIO_BIT_OUT]            = out_q;
      rdata[GPIO_BIT_OE]             = oe_q;
      rdata[GPIO_LSB_MODE +: 2]      = mode_q;
      rdata[GPIO_BIT_PEND]           = pend_q;
      rdata[GPIO_BIT_IN]             = filt_p2;
   end

   assign gpio_o   = out_q;
   assign gpio_oe  = oe_q;
   // Switching MODE to off masks a stale PEND without clearing it.
   assign irq_term = pend_q & (mode_q != GPIO_MODE_OFF);

endmodule

// File: rtl/ervp_user_gpio_bank.sv
// ----------------------------------------------------------------------------
// ervp_user_gpio_bank
// Register-backed bank of NUM_GPIO user GPIO slots behind the user-GPIO APB
// slot decoder. Each slot is an ervp_user_gpio_channel; the bank packs the
// per-slot buses and registers the OR of the interrupt terms.
// Optional feature macro: USER_GPIO_DEBOUNCE_EN (per-slot input debounce,
// DEBOUNCE_CYCLES stable cycles).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rd_en_list   per-slot read strobe (no side effects)
//   wr_en_list   per-slot write strobe
//   wdata_list   per-slot write data, slot i at [32*(i+1)-1 -: 32]
//   rdata_list   per-slot read data, same packing, combinational
//   gpio_i       raw pad inputs
//   gpio_o       pad output values
//   gpio_oe      pad output enables (1 = drive)
//   gpio_irq     registered OR of enabled pending flags
// ----------------------------------------------------------------------------
module ervp_user_gpio_bank
   import ervp_user_gpio_pkg::*;
#(
   parameter int NUM_GPIO        = 16,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_GPIO-1:0]   rd_en_list,
   input  logic [NUM_GPIO-1:0]   wr_en_list,
   input  logic [32*NUM_GPIO-1:0] wdata_list,
   output logic [32*NUM_GPIO-1:0] rdata_list,
   input  logic [NUM_GPIO-1:0]   gpio_i,
   output logic [NUM_GPIO-1:0]   gpio_o,
   output logic [NUM_GPIO-1:0]   gpio_oe,
   output logic                  gpio_irq
);

   logic [NUM_GPIO-1:0] irq_terms;
   logic                unused_rd;

   // Reads are side-effect free; the strobe is accepted but not consumed.
   assign unused_rd = ^rd_en_list;

   for (genvar gi = 0; gi < NUM_GPIO; gi++) begin : g_ch
      ervp_user_gpio_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (wr_en_list[gi]),
         .wdata    (wdata_list[32*gi +: 32]),
         .rdata    (rdata_list[32*gi +: 32]),
         .gpio_i   (gpio_i[gi]),
         .gpio_o   (gpio_o[gi]),
         .gpio_oe  (gpio_oe[gi]),
         .irq_term (irq_terms[gi])
      );
   end

   // Registered interrupt: one edge after PEND.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpio_irq <= 1'b0;
      end else begin
         gpio_irq <= |irq_terms;
      end
   end

endmodule

// File: tb/tb_ervp_user_gpio_bank.sv
module tb_ervp_user_gpio_bank;

   localparam int N = 16;
`ifdef USER_GPIO_DEBOUNCE_EN
   localparam int LAT = 3 + 4;
`else
   localparam int LAT = 3;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N-1:0]      rd_en_list = '0;
   logic [N-1:0]      wr_en_list = '0;
   logic [32*N-1:0]   wdata_list = '0;
   logic [32*N-1:0]   rdata_list;
   logic [N-1:0]      gpio_i = '0;
   logic [N-1:0]      gpio_o;
   logic [N-1:0]      gpio_oe;
   logic              gpio_irq;

   int n_checks = 0;
   int n_fail   = 0;

   ervp_user_gpio_bank #(
      .NUM_GPIO        (N),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en_list (rd_en_list),
      .wr_en_list (wr_en_list),
      .wdata_list (wdata_list),
      .rdata_list (rdata_list),
      .gpio_i     (gpio_i),
      .gpio_o     (gpio_o),
      .gpio_oe    (gpio_oe),
      .gpio_irq   (gpio_irq)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] slot_rd(input int s);
      return rdata_list[32*s +: 32];
   endfunction

   task automatic wr(input int slot, input logic [31:0] d);
      wr_en_list = '0;
      wr_en_list[slot] = 1'b1;
      wdata_list[32*slot +: 32] = d;
      tick(1);
      wr_en_list = '0;
      wdata_list = '0;
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      tick(2);
      n_checks++; if (gpio_o !== 16'h0) begin n_fail++; $display("FAIL rst_gpio_o: got %h want %h", gpio_o, 16'h0); end
      n_checks++; if (gpio_oe !== 16'h0) begin n_fail++; $display("FAIL rst_gpio_oe: got %h want %h", gpio_oe, 16'h0); end
      n_checks++; if (gpio_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", gpio_irq); end
      n_checks++; if (rdata_list !== '0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata_list); end
      rst = 1'b0;
      tick(2);
      n_checks++; if (rdata_list !== '0) begin n_fail++; $display("FAIL post_rst_rdata: got %h want 0", rdata_list); end
      n_checks++; if (gpio_irq !== 1'b0) begin n_fail++; $display("FAIL post_rst_irq: got %b want 0", gpio_irq); end
   endtask

   task automatic test_write;
      logic [32*N-1:0] exp;
      wr(3, 32'h0000_0003);
      exp = '0;
      exp[32*3 +: 32] = 32'h0000_0003;
      n_checks++; if (gpio_o !== 16'h0008) begin n_fail++; $display("FAIL wr_gpio_o: got %h want %h", gpio_o, 16'h0008); end
      n_checks++; if (gpio_oe !== 16'h0008) begin n_fail++; $display("FAIL wr_gpio_oe: got %h want %h", gpio_oe, 16'h0008); end
      n_checks++; if (rdata_list !== exp) begin n_fail++; $display("FAIL wr_rdata_all: got %h want %h", rdata_list, exp); end
      // Only OUT/OE/MODE are writable; IN and reserved bits ignored.
      wr(4, 32'hFFFF_FEE0);
      n_checks++; if (slot_rd(4) !== 32'h0) begin n_fail++; $display("FAIL wr_reserved: got %h want %h", slot_rd(4), 32'h0); end
      wr(4, 32'hFFFF_FFEF);
      n_checks++; if (slot_rd(4) !== 32'h0000_000F) begin n_fail++; $display("FAIL wr_mask: got %h want %h", slot_rd(4), 32'hF); end
      n_checks++; if (gpio_o !== 16'h0018) begin n_fail++; $display("FAIL wr_mask_gpio_o: got %h want %h", gpio_o, 16'h0018); end
      wr(4, 32'h0);
   endtask

   task automatic test_back_to_back;
      wr(1, 32'h0000_0001);
      wr(2, 32'h0000_0002);
      n_checks++; if (slot_rd(1) !== 32'h1) begin n_fail++; $display("FAIL b2b_slot1: got %h want %h", slot_rd(1), 32'h1); end
      n_checks++; if (slot_rd(2) !== 32'h2) begin n_fail++; $display("FAIL b2b_slot2: got %h want %h", slot_rd(2), 32'h2); end
      n_checks++; if (gpio_o !== 16'h000A) begin n_fail++; $display("FAIL b2b_gpio_o: got %h want %h", gpio_o, 16'h000A); end
      n_checks++; if (gpio_oe !== 16'h000C) begin n_fail++; $display("FAIL b2b_gpio_oe: got %h want %h", gpio_oe, 16'h000C); end
      // Two strobes at once: each slot takes its own word.
      wr_en_list = 16'h0C00;
      wdata_list[32*10 +: 32] = 32'h3;
      wdata_list[32*11 +: 32] = 32'h1;
      tick(1);
      wr_en_list = '0;
      wdata_list = '0;
      n_checks++; if (slot_rd(10) !== 32'h3) begin n_fail++; $display("FAIL dual_slot10: got %h want %h", slot_rd(10), 32'h3); end
      n_checks++; if (slot_rd(11) !== 32'h1) begin n_fail++; $display("FAIL dual_slot11: got %h want %h", slot_rd(11), 32'h1); end
   endtask

   task automatic test_rise_pend;
      wr(5, 32'h0000_0004);
      gpio_i[5] = 1'b1;
      tick(LAT - 1);
      n_checks++; if (slot_rd(5) & 32'h10) begin n_fail++; $display("FAIL rise_early: got %h want PEND=0", slot_rd(5)); end
      tick(1);
      n_checks++; if (slot_rd(5) !== 32'h0000_0114) begin n_fail++; $display("FAIL rise_pend: got %h want %h", slot_rd(5), 32'h114); end
      n_checks++; if (gpio_irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_early: got %b want 0", gpio_irq); end
      tick(1);
      n_checks++; if (gpio_irq !== 1'b1) begin n_fail++; $display("FAIL rise_irq: got %b want 1", gpio_irq); end
      gpio_i[5] = 1'b0;
      tick(LAT + 1);
      // Fall is not reported in rise mode, PEND holds.
      n_checks++; if (slot_rd(5) !== 32'h0000_0014) begin n_fail++; $display("FAIL rise_hold: got %h want %h", slot_rd(5), 32'h14); end
      wr(5, 32'h0000_0014);
      n_checks++; if (slot_rd(5) !== 32'h0000_0004) begin n_fail++; $display("FAIL w1c: got %h want %h", slot_rd(5), 32'h4); end
      n_checks++; if (gpio_irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_lag: got %b want 1", gpio_irq); end
      tick(1);
      n_checks++; if (gpio_irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b want 0", gpio_irq); end
   endtask

   task automatic test_set_wins;
      wr(7, 32'h0000_000C);
      gpio_i[7] = 1'b1;
      tick(LAT - 1);
      // W1C lands on the same edge as the set event.
      wr_en_list[7] = 1'b1;
      wdata_list[32*7 +: 32] = 32'h0000_001C;
      tick(1);
      wr_en_list = '0;
      wdata_list = '0;
      n_checks++; if (slot_rd(7) !== 32'h0000_011C) begin n_fail++; $display("FAIL setwins_pend: got %h want %h", slot_rd(7), 32'h11C); end
      tick(1);
      n_checks++; if (gpio_irq !== 1'b1) begin n_fail++; $display("FAIL setwins_irq: got %b want 1", gpio_irq); end
      tick(1);
      n_checks++; if (gpio_irq !== 1'b1) begin n_fail++; $display("FAIL setwins_irq_hold: got %b want 1", gpio_irq); end
      gpio_i[7] = 1'b0;
      tick(LAT + 1);
      wr(7, 32'h0000_0010);
      tick(1);
      n_checks++; if (slot_rd(7) !== 32'h0) begin n_fail++; $display("FAIL setwins_cleanup: got %h want %h", slot_rd(7), 32'h0); end
      n_checks++; if (gpio_irq !== 1'b0) begin n_fail++; $display("FAIL setwins_irq_clr: got %b want 0", gpio_irq); end
   endtask

   task automatic test_mode_off_and_reset;
      wr(0, 32'h0000_0008);
      gpio_i[0] = 1'b1;
      tick(LAT + 1);
      n_checks++; if (slot_rd(0) !== 32'h0000_0108) begin n_fail++; $display("FAIL fall_ignores_rise: got %h want %h", slot_rd(0), 32'h108); end
      gpio_i[0] = 1'b0;
      tick(LAT);
      n_checks++; if (slot_rd(0) !== 32'h0000_0018) begin n_fail++; $display("FAIL fall_pend: got %h want %h", slot_rd(0), 32'h18); end
      tick(1);
      n_checks++; if (gpio_irq !== 1'b1) begin n_fail++; $display("FAIL fall_irq: got %b want 1", gpio_irq); end
      wr(0, 32'h0000_0000);
      n_checks++; if (slot_rd(0) !== 32'h0000_0010) begin n_fail++; $display("FAIL modeoff_pend: got %h want %h", slot_rd(0), 32'h10); end
      tick(1);
      n_checks++; if (gpio_irq !== 1'b0) begin n_fail++; $display("FAIL modeoff_irq: got %b want 0", gpio_irq); end
      // Reset asserted mid-cycle while an edge is in flight.
      wr(9, 32'h0000_0004);
      gpio_i[9] = 1'b1;
      tick(1);
      #2 rst = 1'b1;
      #1;
      n_checks++; if (rdata_list !== '0) begin n_fail++; $display("FAIL midrst_rdata: got %h want 0", rdata_list); end
      n_checks++; if (gpio_o !== 16'h0 || gpio_oe !== 16'h0) begin n_fail++; $display("FAIL midrst_pads: got o=%h oe=%h want 0", gpio_o, gpio_oe); end
      n_checks++; if (gpio_irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b want 0", gpio_irq); end
      tick(2);
      rst = 1'b0;
      tick(LAT + 1);
      // MODE is off after reset, so the held-high pad only shows on IN.
      n_checks++; if (slot_rd(9) !== 32'h0000_0100) begin n_fail++; $display("FAIL postrst_in: got %h want %h", slot_rd(9), 32'h100); end
      n_checks++; if (gpio_irq !== 1'b0) begin n_fail++; $display("FAIL postrst_irq: got %b want 0", gpio_irq); end
      gpio_i[9] = 1'b0;
      tick(LAT + 1);
   endtask

`ifdef USER_GPIO_DEBOUNCE_EN
   task automatic test_debounce;
      wr(2, 32'h0000_0004);
      gpio_i[2] = 1'b1;
      tick(3);
      gpio_i[2] = 1'b0;
      tick(10);
      n_checks++; if (slot_rd(2) !== 32'h0000_0004) begin n_fail++; $display("FAIL db_glitch: got %h want %h", slot_rd(2), 32'h4); end
      gpio_i[2] = 1'b1;
      tick(6);
      gpio_i[2] = 1'b0;
      n_checks++; if (slot_rd(2) !== 32'h0000_0104) begin n_fail++; $display("FAIL db_early: got %h want %h", slot_rd(2), 32'h104); end
      tick(1);
      n_checks++; if (slot_rd(2) !== 32'h0000_0114) begin n_fail++; $display("FAIL db_pend: got %h want %h", slot_rd(2), 32'h114); end
      tick(10);
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_back_to_back();
      test_rise_pend();
      test_set_wins();
      test_mode_off_and_reset();
`ifdef USER_GPIO_DEBOUNCE_EN
      test_debounce();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
